// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state encoding and frame constants shared by the UART RX/TX pair
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// uart_rx_if : serial line plus byte-stream handshake of the UART receiver
// Revision   : 1.0
// ============================================================================
interface uart_rx_if;

  logic                           rx_line;
  logic [uart_pkg::DATA_BITS-1:0] rx_data;
  logic                           rx_valid;
  logic                           rx_ready;
  logic                           framing_error;
  logic                           overrun;
  logic                           busy;

  // master: the receiver itself; slave: line driver and byte consumer
  modport master (
    input  rx_line,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output framing_error,
    output overrun,
    output busy
  );

  modport slave (
    output rx_line,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  framing_error,
    input  overrun,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// sync_2ff : two-flop synchronizer for a single asynchronous bit
// Revision : 1.0
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic d,
  output logic      q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx  : 8N1 UART receiver, mid-bit sampling, valid/ready byte output
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8  // must be at least 4
) (
  input  wire logic  clock,
  input  wire logic  reset,
  uart_rx_if.master  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 edge_q, edge_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_q, overrun_d;
  logic                 byte_done;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clock),
    .rst (reset),
    .d   (bus.rx_line),
    .q   (rx_s)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    edge_d          = rx_s;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;
    byte_done       = 1'b0;

    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        // only a 1->0 transition starts a frame, so a stuck-low line is ignored
        if (edge_q && !rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == C_CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == C_BIT_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            byte_done = 1'b1;
          end else begin
            framing_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // a byte completing while the consumer still holds the previous one is dropped
    if (byte_done) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      edge_q          <= 1'b1;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      edge_q          <= edge_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.framing_error = framing_error_q;
  assign bus.overrun       = overrun_q;
  assign bus.busy          = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : self-checking bench for uart_rx (CLKS_PER_BIT = 8)
// Revision   : 1.0
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 8;
  // two synchronizer stages precede the falling-edge detection cycle
  localparam int LAT = CPB / 2 + 9 * CPB + 1 + 2;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    int         exp_fe;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, deliver_cyc = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0, valid_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] exp_q[$];

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_line = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  // monitor: pulse widths, busy time and scoreboard on byte delivery
  always @(negedge clk) begin
    if (bus.framing_error) begin
      fe_cnt++;
      check("framing_error_width", {31'd0, fe_prev}, 32'd0);
    end
    if (bus.overrun) begin
      ov_cnt++;
      check("overrun_width", {31'd0, ov_prev}, 32'd0);
    end
    if (bus.busy) busy_cnt++;
    if (bus.rx_valid && (!valid_prev || bus.rx_data != data_prev)) begin
      deliver_cyc = cyc;
      if (exp_q.size() == 0) check("sb_unexpected_byte", {24'd0, bus.rx_data}, 32'hFFFF_FFFF);
      else check("sb_byte", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
    end
    fe_prev    = bus.framing_error;
    ov_prev    = bus.overrun;
    valid_prev = bus.rx_valid;
    data_prev  = bus.rx_data;
  end

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   fe0, ov0, b0, start_cyc;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_fe: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_fe: 0};
    vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_fe: 1};
    vecs[4] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_fe: 0};
    vecs[5] = '{data: 8'h6E, stop: 1'b0, exp_valid: 1'b0, exp_fe: 1};

    bus.rx_line  = 1'b1;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("reset_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("reset_framing", {31'd0, bus.framing_error}, 32'd0);
    check("reset_overrun", {31'd0, bus.overrun}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[k]) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      if (vecs[k].stop) exp_q.push_back(vecs[k].data);
      start_cyc = cyc;
      send_frame(vecs[k].data, vecs[k].stop);
      bus.rx_line = 1'b1;
      repeat (4) @(negedge clk);
      check("vec_rx_valid", {31'd0, bus.rx_valid}, {31'd0, vecs[k].exp_valid});
      check("vec_framing_count", fe_cnt - fe0, vecs[k].exp_fe);
      check("vec_overrun_count", ov_cnt - ov0, 0);
      check("vec_busy_idle", {31'd0, bus.busy}, 32'd0);
      if (vecs[k].exp_valid) begin
        check("vec_rx_data", {24'd0, bus.rx_data}, {24'd0, vecs[k].data});
        check("vec_latency", deliver_cyc - start_cyc, LAT);
      end
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      @(negedge clk);
      check("vec_consumed", {31'd0, bus.rx_valid}, 32'd0);
    end

    // two-cycle low glitch: START aborts at its mid-bit sample
    fe0 = fe_cnt; ov0 = ov_cnt; b0 = busy_cnt;
    bus.rx_line = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_line = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy_cycles", busy_cnt - b0, CPB / 2);
    check("glitch_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("glitch_framing", fe_cnt - fe0, 0);
    check("glitch_overrun", ov_cnt - ov0, 0);
    check("glitch_busy", {31'd0, bus.busy}, 32'd0);

    // bad stop bit followed by a long low line: one error, no retrigger
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    b0 = busy_cnt;
    repeat (40) @(negedge clk);
    check("low_framing_count", fe_cnt - fe0, 1);
    check("low_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("low_no_retrigger", busy_cnt - b0, 0);
    bus.rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check("low_busy_after_high", {31'd0, bus.busy}, 32'd0);

    // back-to-back frames with no consumer: second byte is dropped
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    bus.rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_pulse_count", ov_cnt - ov0, 1);
    check("ovr_rx_data_kept", {24'd0, bus.rx_data}, 32'h11);
    check("ovr_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);

    // same pair, consumer accepts exactly on the second completion cycle
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        check("swap_rx_data", {24'd0, bus.rx_data}, 32'h22);
        check("swap_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
      end
    join
    bus.rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check("swap_overrun", ov_cnt - ov0, 0);
    check("swap_valid_held", {31'd0, bus.rx_valid}, 32'd1);

    // reset during data bit 4 abandons the frame silently
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (5 * CPB + 4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("midrst_framing", {31'd0, bus.framing_error}, 32'd0);
        check("midrst_overrun", {31'd0, bus.overrun}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
      end
    join
    bus.rx_line = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_idle_after", {31'd0, bus.busy}, 32'd0);
    check("midrst_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    exp_q.push_back(8'h5A);
    start_cyc = cyc;
    send_frame(8'h5A, 1'b1);
    bus.rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_rx_data", {24'd0, bus.rx_data}, 32'h5A);
    check("post_rst_rx_valid", {31'd0, bus.rx_valid}, 32'd1);
    check("post_rst_latency", deliver_cyc - start_cyc, LAT);

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 8: clock cycles per serial bit; SHALL be at least 4; the counter width is sized to hold CLKS_PER_BIT-1.
REQ-002 Port clock  input  1  single clock; all logic on the rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port rx_line  input  1  asynchronous serial input; idles high.
REQ-005 Port rx_data  output  8  last received byte.
REQ-006 Port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 Port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 Port framing_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port overrun  output  1  one-cycle pulse: a completed byte was dropped.
REQ-010 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 rx_line SHALL pass through a 2-flop synchronizer with both flops reset to 1; all logic uses only the synchronized value (rx_s).
REQ-012 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-013 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-014 In IDLE, the FSM SHALL leave IDLE only on a falling edge of rx_s (previous 1, current 0). On that edge it SHALL move to START with the bit counter at 0. A line held low SHALL NOT retrigger.
REQ-015 In START, rx_s SHALL be sampled when the counter reaches CLKS_PER_BIT/2-1 (integer division).
 - Sample 1: glitch; return to IDLE, no output.
 - Sample 0: move to DATA with the counter cleared.
REQ-016 In DATA, rx_s SHALL be sampled every CLKS_PER_BIT cycles (bit centres).
 - Each sample SHALL shift into bit 7 of the shift register while the register shifts right.
 - After the 8th sample the FSM SHALL move to STOP.
REQ-017 In STOP, rx_s SHALL be sampled CLKS_PER_BIT cycles after the last data sample. The FSM SHALL return to IDLE on the next cycle in every case.
REQ-018 Stop sample 1: the byte SHALL be delivered per REQ-020/REQ-021. Stop sample 0: framing_error SHALL pulse for 1 cycle, the byte SHALL be discarded, and rx_data/rx_valid SHALL stay unchanged.
REQ-019 Latency: counted from the falling-edge detection cycle to rx_valid rising, the delay SHALL be CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
REQ-020 rx_valid SHALL stay high until a cycle with rx_valid && rx_ready. That cycle SHALL clear rx_valid unless a new byte completes in the same cycle.
REQ-021 Byte completion while rx_valid is low, or while rx_valid && rx_ready: rx_data SHALL load the new byte and rx_valid SHALL be 1 next cycle. No overrun.
REQ-022 Byte completion while rx_valid is high and rx_ready is low:
 - overrun SHALL pulse for 1 cycle;
 - the new byte SHALL be dropped;
 - rx_data SHALL keep the old byte.
REQ-023 rx_ready while rx_valid is low SHALL have no effect.
REQ-024 framing_error and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-025 While reset is high:
 - FSM SHALL go to IDLE;
 - counters and shift register SHALL be 0;
 - synchronizer flops and the edge-detect register SHALL be 1;
 - rx_data SHALL be 8'h00;
 - rx_valid, framing_error, overrun and busy SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without any output pulse. After reset falls, a start edge SHALL be needed to begin reception.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP) and localparam DATA_BITS = 8. The sibling transmitter SHALL share this package.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff, with a reset-value parameter. It is instantiated once.

Verification (CLKS_PER_BIT = 8)
REQ-029 Frame 0xA5 with stop=1, rx_ready held 0 -> rx_valid=1 and rx_data=8'hA5 at the REQ-019 latency; busy=0 afterwards; no error pulses.
REQ-030 Low glitch on rx_line of 2 cycles -> START aborts at its mid-bit sample; rx_valid, framing_error and overrun stay 0; busy returns to 0.
REQ-031 Frame 0x3C with stop bit driven 0, then line held low 40 cycles -> exactly one framing_error pulse, rx_valid stays 0, no retrigger until the line goes high then falls.
REQ-032 Frames 0x11 then 0x22 back-to-back with rx_ready=0 -> one overrun pulse at the second completion, rx_data stays 8'h11. Repeat with rx_ready=1 on the second completion cycle -> rx_data=8'h22, rx_valid stays 1, no overrun.
REQ-033 Reset asserted during data bit 4 of frame 0xFF, then frame 0x5A -> all outputs read as in REQ-025 during reset; no pulses; the next frame yields rx_data=8'h5A.
